// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
// Size encodings, FSM state type and the alignment rule live here.
package mau_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCapt,
      StWrite,
      StDone,
      StErr
   } state_e;

   // size 2'b11 aliases word, so size[1] alone selects word alignment
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mau_lane.sv
// Little-endian lane handling: merges store data into a RAM word and
// extracts a right-justified, optionally sign-extended load value.
module mau_lane
   import mau_pkg::*;
(
   input  logic [1:0]        size,
   input  logic [1:0]        lo,
   input  logic              sext,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rword,
   output logic [DATA_W-1:0] merged,
   output logic [DATA_W-1:0] loaded
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = rword[{lo, 3'b000} +: 8];
   assign half_lane = rword[{lo[1], 4'b0000} +: 16];

   always_comb begin
      merged = rword;
      loaded = rword;
      case (size)
         SZ_BYTE: begin
            merged[{lo, 3'b000} +: 8] = wdata[7:0];
            loaded = {{24{sext & byte_lane[7]}}, byte_lane};
         end
         SZ_HALF: begin
            merged[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            loaded = {{16{sext & half_lane[15]}}, half_lane};
         end
         default: begin
            merged = wdata;
            loaded = rword;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit in front of a single-port RAM with registered read.
// Partial stores run read-modify-write; misaligned accesses end in ERR.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W+1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   state_e state_q, state_d;

   logic              wr_q;
   logic [1:0]        size_q;
   logic              sext_q;
   logic [1:0]        lo_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_din_q;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] loaded;

   mau_lane u_lane (
      .size   (size_q),
      .lo     (lo_q),
      .sext   (sext_q),
      .wdata  (wdata_q),
      .rword  (ram_dout),
      .merged (merged),
      .loaded (loaded)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (req) begin
               if (misaligned(size, addr[1:0])) begin
                  state_d = StErr;
               end else if (wr && size[1]) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead:  state_d = StCapt;
         StCapt:  state_d = wr_q ? StWrite : StDone;
         StWrite: state_d = StDone;
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy   = (state_q != StIdle);
      done   = (state_q == StDone) || (state_q == StErr);
      err    = (state_q == StErr);
      ram_we = (state_q == StWrite);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         sext_q     <= 1'b0;
         lo_q       <= 2'b00;
         wdata_q    <= '0;
         rdata_q    <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         if ((state_q == StIdle) && req) begin
            wr_q       <= wr;
            size_q     <= size;
            sext_q     <= sext;
            lo_q       <= addr[1:0];
            wdata_q    <= wdata;
            ram_addr_q <= addr[ADDR_W+1:2];
            ram_din_q  <= wdata;
         end
         // ram_dout holds the addressed word during CAPT
         if (state_q == StCapt) begin
            if (wr_q) begin
               ram_din_q <= merged;
            end else begin
               rdata_q <= loaded;
            end
         end
      end
   end

   assign rdata    = rdata_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level memory model with
// per-cycle output comparison plus directed literal checks.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst, req, wr, sext;
   logic [1:0]  size;
   logic [11:0] addr;
   logic [31:0] wdata, rdata, ram_din, ram_dout;
   logic        done, err, busy, ram_we;
   logic [9:0]  ram_addr;

   bit [31:0] ram [0:1023];
   bit [7:0]  mb  [0:4095];

   int checks = 0, failures = 0;
   int cyc = 0;
   bit chk_en = 0;

   int          busy_lo = 1, busy_hi = 0, done_cyc = -1, we_cyc = -1;
   bit          err_exp = 0;
   logic [31:0] exp_din = '0;
   logic [9:0]  exp_waddr = '0;
   logic [31:0] model_rdata = '0, pend_val = '0;
   int          pend_cyc = 0;
   bit          pend_valid = 0;
   int          we_count = 0, done_count = 0, err_count = 0, last_done_cyc = -1;

   mem_access_unit #(.ADDR_W(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wr       (wr),
      .size     (size),
      .sext     (sext),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .done     (done),
      .err      (err),
      .busy     (busy),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Accept an access whose req is sampled at edge s; schedule its outputs.
   task automatic model_accept(input int s, input logic w, input logic [1:0] sz,
                               input logic sx, input logic [11:0] a, input logic [31:0] wd);
      int nb, lat;
      bit mis;
      logic [31:0] v;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = (int'(a) % nb) != 0;
      if (mis) lat = 1;
      else if (w && nb == 4) lat = 2;
      else if (w) lat = 4;
      else lat = 3;
      busy_lo  = s;
      busy_hi  = s + lat - 1;
      done_cyc = busy_hi;
      err_exp  = mis;
      we_cyc   = -1;
      if (!mis && w) begin
         for (int i = 0; i < nb; i++) mb[int'(a) + i] = wd[8*i +: 8];
         for (int j = 0; j < 4; j++) v[8*j +: 8] = mb[{a[11:2], 2'b00} + j];
         exp_din   = v;
         exp_waddr = a[11:2];
         we_cyc    = (nb == 4) ? s : s + 2;
      end
      if (!mis && !w) begin
         v = '0;
         for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[int'(a) + i];
         if (sx && nb < 4 && v[8*nb-1]) begin
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
         end
         pend_val   = v;
         pend_cyc   = s + 2;
         pend_valid = 1;
      end
   endtask

   task automatic model_reset(input int r);
      if (busy_hi >= r) busy_hi = r - 1;
      if (done_cyc >= r) done_cyc = -1;
      if (we_cyc >= r) we_cyc = -1;
      pend_val   = '0;
      pend_cyc   = r;
      pend_valid = 1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (pend_valid && cyc >= pend_cyc) begin
            model_rdata = pend_val;
            pend_valid  = 0;
         end
         chk("done", done, cyc == done_cyc);
         chk("err", err, (cyc == done_cyc) && err_exp);
         chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
         chk("ram_we", ram_we, cyc == we_cyc);
         chk("rdata", rdata, model_rdata);
         if (cyc == we_cyc) begin
            chk("ram_addr", ram_addr, exp_waddr);
            chk("ram_din", ram_din, exp_din);
         end
         if (ram_we) we_count++;
         if (err) err_count++;
         if (done) begin
            done_count++;
            last_done_cyc = cyc;
         end
      end
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [11:0] a, input logic [31:0] wd, output int s);
      @(posedge clk); #1;
      req = 1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
      s = cyc + 1;
      model_accept(s, w, sz, sx, a, wd);
      @(posedge clk); #1;
      req = 0;
      repeat (5) @(posedge clk);
      #1;
   endtask

   int s, we0, d0, e0;
   bit [7:0] saved [0:3];

   initial begin
      rst = 0; req = 0; wr = 0; size = 2'b00; sext = 0; addr = '0; wdata = '0;
      ram[3] = 32'h8081_7F01;
      mb[12] = 8'h01; mb[13] = 8'h7F; mb[14] = 8'h81; mb[15] = 8'h80;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_addr", ram_addr, 10'h0);
      chk("rst_ram_din", ram_din, 32'h0);
      rst = 1;
      chk_en = 1;

      issue(1'b0, 2'b00, 1'b1, 12'h00E, 32'h0, s);
      chk("lb_sext_rdata", rdata, 32'hFFFF_FF81);
      chk("lb_latency", last_done_cyc - s + 1, 3);
      issue(1'b0, 2'b00, 1'b0, 12'h00E, 32'h0, s);
      chk("lb_zext_rdata", rdata, 32'h0000_0081);

      we0 = we_count;
      issue(1'b1, 2'b01, 1'b0, 12'h00E, 32'h1234_5678, s);
      chk("sh_ram3", ram[3], 32'h5678_7F01);
      chk("sh_latency", last_done_cyc - s + 1, 4);
      chk("sh_we_pulses", we_count - we0, 1);

      we0 = we_count;
      issue(1'b1, 2'b10, 1'b0, 12'h00C, 32'hDEAD_BEEF, s);
      chk("sw_ram3", ram[3], 32'hDEAD_BEEF);
      chk("sw_latency", last_done_cyc - s + 1, 2);
      chk("sw_we_pulses", we_count - we0, 1);

      we0 = we_count; e0 = err_count;
      issue(1'b0, 2'b01, 1'b0, 12'h001, 32'h0, s);
      chk("mis_h_latency", last_done_cyc - s + 1, 1);
      chk("mis_h_err", err_count - e0, 1);
      chk("mis_h_rdata", rdata, 32'h0000_0081);
      issue(1'b1, 2'b10, 1'b0, 12'h00E, 32'h5555_5555, s);
      chk("mis_w_latency", last_done_cyc - s + 1, 1);
      chk("mis_we_pulses", we_count - we0, 0);
      chk("mis_w_ram3", ram[3], 32'hDEAD_BEEF);

      issue(1'b0, 2'b11, 1'b1, 12'h00C, 32'h0, s);
      chk("lw_sz11_rdata", rdata, 32'hDEAD_BEEF);

      // Reset while a byte store sits in CAPT
      we0 = we_count; d0 = done_count;
      for (int i = 0; i < 4; i++) saved[i] = mb[16 + i];
      @(posedge clk); #1;
      req = 1; wr = 1; size = 2'b00; sext = 0; addr = 12'h010; wdata = 32'h0000_00AA;
      s = cyc + 1;
      model_accept(s, 1'b1, 2'b00, 1'b0, 12'h010, 32'h0000_00AA);
      @(posedge clk); #1;
      req = 0;
      @(posedge clk); #1;
      rst = 0;
      model_reset(s + 2);
      @(posedge clk); #1;
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_done", done, 1'b0);
      chk("rstmid_ram_we", ram_we, 1'b0);
      chk("rstmid_ram_addr", ram_addr, 10'h0);
      chk("rstmid_ram_din", ram_din, 32'h0);
      chk("rstmid_rdata", rdata, 32'h0);
      rst = 1;
      for (int i = 0; i < 4; i++) mb[16 + i] = saved[i];
      repeat (5) @(posedge clk);
      #1;
      chk("rstmid_we_pulses", we_count - we0, 0);
      chk("rstmid_done_pulses", done_count - d0, 0);
      chk("rstmid_ram4", ram[4], 32'h0);

      // req held high across a whole load: second access sampled after DONE
      d0 = done_count;
      @(posedge clk); #1;
      req = 1; wr = 0; size = 2'b00; sext = 1; addr = 12'h00F; wdata = '0;
      s = cyc + 1;
      model_accept(s, 1'b0, 2'b00, 1'b1, 12'h00F, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      model_accept(s + 4, 1'b0, 2'b00, 1'b1, 12'h00F, 32'h0);
      @(posedge clk); #1;
      req = 0;
      repeat (6) @(posedge clk);
      #1;
      chk("held_done_pulses", done_count - d0, 2);
      chk("held_second_done", last_done_cyc - s, 6);
      chk("held_rdata", rdata, 32'hFFFF_FFDE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
